orb_hamming_best_match: RTL and testbench
=========================================

# orb_hamming_best_match

Streaming BRIEF descriptor matcher for the ORB match path. It latches one query descriptor, then takes a stream of candidate descriptors, one per cycle. For each candidate it computes the Hamming distance in a fixed-latency pipeline and tracks the best and second-best distances plus the index of the best candidate. When the stream ends it reports the result and a Lowe-style ratio/threshold verdict to the match-selection logic downstream.

## Interface
Parameters:
- DESC_W, 256, descriptor width in bits
- IDX_W, 10, candidate index width
- DIST_THRESH, 64, maximum best distance accepted as a match
- RATIO_NUM / RATIO_DEN, 3 / 4, ratio test: accept when best*RATIO_DEN < second*RATIO_NUM

Ports:
- i_clk  in  1  clock, all logic on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_start  in  1  begin new query; accepted only in IDLE or DONE
- i_query  in  DESC_W  query descriptor, sampled with accepted i_start
- i_cand_valid  in  1  candidate present this cycle (honoured only in RUN)
- i_cand  in  DESC_W  candidate descriptor
- i_cand_last  in  1  marks final candidate; ignored unless i_cand_valid
- o_busy  out  1  high in RUN and DRAIN
- o_done  out  1  one-cycle pulse, results valid
- o_best_idx  out  IDX_W  index of best candidate (0-based arrival order)
- o_best_dist  out  DIST_W  best Hamming distance
- o_second_dist  out  DIST_W  second-best distance
- o_match_ok  out  1  threshold and ratio test both pass

DIST_W = $clog2(DESC_W+1) (9 for 256).

## Operation
- FSM: IDLE -> RUN on i_start; RUN -> DRAIN when a valid candidate with i_cand_last is accepted; DRAIN -> DONE when the last candidate's compare commits; DONE -> RUN on i_start, otherwise holds.
- i_start also resets best/second to DIST_MAX = 2^DIST_W-1, the index counter to 0 and best_idx to 0. i_start is ignored in RUN/DRAIN.
- Accepted candidate: XOR with the latched query, popcount, then compare:
  - if dist < best: second <= best, best <= dist, best_idx <= idx
  - else if dist < second: second <= dist
  - Strict compares, so the earliest index wins ties. A tie with best sets second = best.
- Index counter increments per accepted candidate. It wraps modulo 2^IDX_W; the caller limits stream length.
- i_cand_valid outside RUN is dropped.
- o_match_ok is computed at the DONE transition:
  - (best <= DIST_THRESH) && (best*RATIO_DEN < second*RATIO_NUM)
  - Products use DIST_W+3 bit arithmetic; no truncation.
  - A single candidate leaves second = DIST_MAX, so the ratio passes.
- Per-stage valid/last/index registers travel with the data. They are resettable and are not built from reset-less delay lines.

## Timing
- Pipeline, relative to edge N that accepts a candidate:
  - N+1: XOR register
  - N+2: 4 partial popcounts of 64 bits
  - N+3: sum
  - N+4: compare and best/second update
- Throughput: one candidate per cycle, no stalls.
- For a last candidate accepted at edge N: DONE entered and o_done high after edge N+4 for exactly one cycle. o_busy falls at the same edge.
- o_best_idx, o_best_dist, o_second_dist and o_match_ok change only at the DONE transition. They then hold until the next DONE.
- Reset values: state IDLE, o_busy 0, o_done 0, o_best_idx 0, o_best_dist DIST_MAX, o_second_dist DIST_MAX, o_match_ok 0. All pipeline valids are cleared.
- Reset mid-RUN/DRAIN discards in-flight candidates; no o_done follows.
- i_start in the same cycle as o_done is accepted; the new query begins the next cycle.

## Structure
- Package orb_match_pkg holds:
  - DESC_W_DEF and DIST_W
  - the DIST_MAX function
  - typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE}
  - desc_t / dist_t typedefs
- One sub-module, hamming_popcount: a 2-stage registered popcount of DESC_W bits with a valid sideband.
- The top level holds the XOR stage, FSM, compare, and ratio logic.

## Test plan
- Query 0, candidates with popcounts {100, 40, 70, 40(last)} -> o_best_idx 1, best 40, second 40, o_match_ok 0; o_done 4 edges after last.
- Query all-ones, candidates {all-ones, all-zeros(last)} -> best_idx 0, best 0, second 256, o_match_ok 1.
- Single candidate at distance 65 -> best 65, second 511, o_match_ok 0 (threshold). Repeat at distance 64 -> o_match_ok 1.
- Ratio boundary: distances {30, 40} -> 120 < 120 is false, so o_match_ok 0. Distances {29, 40} -> 116 < 120, so o_match_ok 1.
- i_rst pulsed 2 cycles after a last candidate -> no o_done; outputs return to reset values. A new query then completes normally.
- Back-to-back queries: i_start coincident with o_done, i_cand_valid held in gaps outside RUN -> gap candidates ignored; each query reports its own result.

Source files
------------

// File: rtl/orb_match_pkg.sv
// rtl/orb_match_pkg.sv - shared types, widths and helpers for the ORB descriptor matcher
package orb_match_pkg;

  localparam int DESC_W_DEF = 256;
  localparam int DIST_W     = $clog2(DESC_W_DEF + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef logic [DESC_W_DEF-1:0] desc_t;
  typedef logic [DIST_W-1:0]     dist_t;

  // Largest value a distance register of width w can hold; used as "no candidate yet".
  function automatic int dist_max(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/orb_hamming_best_match_if.sv
// rtl/orb_hamming_best_match_if.sv - query/candidate stream and result bundle of the matcher
interface orb_hamming_best_match_if #(
  parameter int DESC_W = 256,
  parameter int IDX_W  = 10
);
  localparam int DIST_W = $clog2(DESC_W + 1);

  logic              i_start;
  logic [DESC_W-1:0] i_query;
  logic              i_cand_valid;
  logic [DESC_W-1:0] i_cand;
  logic              i_cand_last;
  logic              o_busy;
  logic              o_done;
  logic [IDX_W-1:0]  o_best_idx;
  logic [DIST_W-1:0] o_best_dist;
  logic [DIST_W-1:0] o_second_dist;
  logic              o_match_ok;

  modport master (
    output i_start, i_query, i_cand_valid, i_cand, i_cand_last,
    input  o_busy, o_done, o_best_idx, o_best_dist, o_second_dist, o_match_ok
  );

  modport slave (
    input  i_start, i_query, i_cand_valid, i_cand, i_cand_last,
    output o_busy, o_done, o_best_idx, o_best_dist, o_second_dist, o_match_ok
  );
endinterface

// File: rtl/hamming_popcount.sv
// rtl/hamming_popcount.sv - two-stage registered popcount (4 partials, then sum) with valid/tag sideband
module hamming_popcount #(
  parameter int DESC_W = 256,
  parameter int TAG_W  = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             bits_valid,
  input  logic [DESC_W-1:0]                bits,
  input  logic [TAG_W-1:0]                 bits_tag,
  output logic                             count_valid,
  output logic [$clog2(DESC_W + 1)-1:0]    count,
  output logic [TAG_W-1:0]                 count_tag
);

  localparam int DIST_W = $clog2(DESC_W + 1);
  localparam int PART_W = (DESC_W + 3) / 4;
  localparam int PCNT_W = $clog2(PART_W + 1);

  logic [PCNT_W-1:0] part_c [4];
  logic [PCNT_W-1:0] part_q [4];
  logic              part_valid;
  logic [TAG_W-1:0]  part_tag;

  always_comb begin
    for (int p = 0; p < 4; p++) begin
      part_c[p] = '0;
      for (int j = 0; j < PART_W; j++) begin
        if (p * PART_W + j < DESC_W) begin
          part_c[p] = part_c[p] + PCNT_W'(bits[p * PART_W + j]);
        end
      end
    end
  end

  // Sideband registers are reset so a flush leaves nothing in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      part_valid  <= 1'b0;
      part_tag    <= '0;
      count_valid <= 1'b0;
      count_tag   <= '0;
    end else begin
      part_valid  <= bits_valid;
      part_tag    <= bits_tag;
      count_valid <= part_valid;
      count_tag   <= part_tag;
    end
  end

  always_ff @(posedge clk) begin
    part_q <= part_c;
    count  <= DIST_W'(part_q[0]) + DIST_W'(part_q[1]) + DIST_W'(part_q[2]) + DIST_W'(part_q[3]);
  end

endmodule

// File: rtl/orb_hamming_best_match.sv
// rtl/orb_hamming_best_match.sv - streaming Hamming best/second-best matcher with threshold and ratio verdict
module orb_hamming_best_match
  import orb_match_pkg::*;
#(
  parameter int DESC_W      = DESC_W_DEF,
  parameter int IDX_W       = 10,
  parameter int DIST_THRESH = 64,
  parameter int RATIO_NUM   = 3,
  parameter int RATIO_DEN   = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  orb_hamming_best_match_if.slave bus
);

  localparam int D_W    = $clog2(DESC_W + 1);
  localparam int PROD_W = D_W + 3;
  localparam int TAG_W  = IDX_W + 1;
  localparam logic [D_W-1:0] DMAX = D_W'(dist_max(D_W));

  state_t state, state_n;

  logic              start_acc, cand_acc, commit_last;
  logic [DESC_W-1:0] query_q;
  logic [IDX_W-1:0]  idx_cnt;

  logic              s0_valid, x_valid, pc_valid;
  logic [TAG_W-1:0]  s0_tag, x_tag, pc_tag;
  logic [DESC_W-1:0] s0_cand, x_bits;
  logic [D_W-1:0]    pc_count;

  logic [D_W-1:0]    best_q, second_q, best_n, second_n;
  logic [IDX_W-1:0]  best_idx_q, best_idx_n;
  logic [PROD_W-1:0] lhs, rhs;
  logic              match_n;

  logic              done_q, match_q;
  logic [IDX_W-1:0]  out_idx_q;
  logic [D_W-1:0]    out_best_q, out_second_q;

  assign start_acc   = bus.i_start && (state == IDLE || state == DONE);
  assign cand_acc    = bus.i_cand_valid && (state == RUN);
  assign commit_last = pc_valid && pc_tag[IDX_W];

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.i_start) state_n = RUN;
      RUN:     if (cand_acc && bus.i_cand_last) state_n = DRAIN;
      DRAIN:   if (commit_last) state_n = DONE;
      DONE:    if (bus.i_start) state_n = RUN;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (start_acc) query_q <= bus.i_query;
    s0_cand <= bus.i_cand;
    x_bits  <= s0_cand ^ query_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      idx_cnt  <= '0;
      s0_valid <= 1'b0;
      s0_tag   <= '0;
      x_valid  <= 1'b0;
      x_tag    <= '0;
    end else begin
      if (start_acc)     idx_cnt <= '0;
      else if (cand_acc) idx_cnt <= idx_cnt + 1'b1;
      s0_valid <= cand_acc;
      s0_tag   <= {bus.i_cand_last, idx_cnt};
      x_valid  <= s0_valid;
      x_tag    <= s0_tag;
    end
  end

  hamming_popcount #(
    .DESC_W (DESC_W),
    .TAG_W  (TAG_W)
  ) u_popcount (
    .clk         (i_clk),
    .rst         (i_rst),
    .bits_valid  (x_valid),
    .bits        (x_bits),
    .bits_tag    (x_tag),
    .count_valid (pc_valid),
    .count       (pc_count),
    .count_tag   (pc_tag)
  );

  // Strict compares keep the earliest index on ties; a tie with best lands in second.
  always_comb begin
    best_n     = best_q;
    second_n   = second_q;
    best_idx_n = best_idx_q;
    if (pc_valid) begin
      if (pc_count < best_q) begin
        second_n   = best_q;
        best_n     = pc_count;
        best_idx_n = pc_tag[IDX_W-1:0];
      end else if (pc_count < second_q) begin
        second_n = pc_count;
      end
    end
  end

  assign lhs     = PROD_W'(best_n) * PROD_W'(RATIO_DEN);
  assign rhs     = PROD_W'(second_n) * PROD_W'(RATIO_NUM);
  assign match_n = (PROD_W'(best_n) <= PROD_W'(DIST_THRESH)) && (lhs < rhs);

  always_ff @(posedge i_clk) begin
    if (i_rst || start_acc) begin
      best_q     <= DMAX;
      second_q   <= DMAX;
      best_idx_q <= '0;
    end else begin
      best_q     <= best_n;
      second_q   <= second_n;
      best_idx_q <= best_idx_n;
    end
  end

  // Published results move only when the final candidate commits.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      done_q       <= 1'b0;
      match_q      <= 1'b0;
      out_idx_q    <= '0;
      out_best_q   <= DMAX;
      out_second_q <= DMAX;
    end else begin
      done_q <= (state == DRAIN) && commit_last;
      if ((state == DRAIN) && commit_last) begin
        match_q      <= match_n;
        out_idx_q    <= best_idx_n;
        out_best_q   <= best_n;
        out_second_q <= second_n;
      end
    end
  end

  assign bus.o_busy        = (state == RUN) || (state == DRAIN);
  assign bus.o_done        = done_q;
  assign bus.o_best_idx    = out_idx_q;
  assign bus.o_best_dist   = out_best_q;
  assign bus.o_second_dist = out_second_q;
  assign bus.o_match_ok    = match_q;

endmodule

// File: tb/tb_orb_hamming_best_match.sv
// tb/tb_orb_hamming_best_match.sv - directed self-checking bench for orb_hamming_best_match
module tb_orb_hamming_best_match;
  import orb_match_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  orb_hamming_best_match_if #(.DESC_W(256), .IDX_W(10)) bus ();

  orb_hamming_best_match dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic desc_t ones_n(input int k);
    desc_t d = '0;
    for (int i = 0; i < k; i++) d[i] = 1'b1;
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_query(input desc_t q);
    bus.i_start = 1'b1;
    bus.i_query = q;
    tick();
    bus.i_start = 1'b0;
  endtask

  task automatic send_cands(input desc_t c [8], input int n);
    for (int i = 0; i < n; i++) begin
      bus.i_cand_valid = 1'b1;
      bus.i_cand       = c[i];
      bus.i_cand_last  = (i == n - 1);
      tick();
    end
    bus.i_cand_valid = 1'b0;
    bus.i_cand_last  = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!bus.o_done && lat < 20);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_cmp++; if (bus.o_busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", bus.o_busy); end
    n_cmp++; if (bus.o_done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", bus.o_done); end
    n_cmp++; if (bus.o_best_idx !== 10'd0) begin n_bad++; $display("FAIL rst_idx: got %0d want 0", bus.o_best_idx); end
    n_cmp++; if (bus.o_best_dist !== 9'd511) begin n_bad++; $display("FAIL rst_best: got %0d want 511", bus.o_best_dist); end
    n_cmp++; if (bus.o_second_dist !== 9'd511) begin n_bad++; $display("FAIL rst_second: got %0d want 511", bus.o_second_dist); end
    n_cmp++; if (bus.o_match_ok !== 1'b0) begin n_bad++; $display("FAIL rst_ok: got %b want 0", bus.o_match_ok); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    desc_t c [8];
    int    lat;
    c[0] = ones_n(100); c[1] = ones_n(40); c[2] = ones_n(70); c[3] = ones_n(40);
    start_query('0);
    n_cmp++; if (bus.o_busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy_run: got %b want 1", bus.o_busy); end
    send_cands(c, 4);
    wait_done(lat);
    n_cmp++; if (lat != 4) begin n_bad++; $display("FAIL basic_latency: got %0d want 4", lat); end
    n_cmp++; if (bus.o_best_idx !== 10'd1) begin n_bad++; $display("FAIL basic_idx: got %0d want 1", bus.o_best_idx); end
    n_cmp++; if (bus.o_best_dist !== 9'd40) begin n_bad++; $display("FAIL basic_best: got %0d want 40", bus.o_best_dist); end
    n_cmp++; if (bus.o_second_dist !== 9'd40) begin n_bad++; $display("FAIL basic_second: got %0d want 40", bus.o_second_dist); end
    n_cmp++; if (bus.o_match_ok !== 1'b0) begin n_bad++; $display("FAIL basic_ok: got %b want 0", bus.o_match_ok); end
    n_cmp++; if (bus.o_busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_done: got %b want 0", bus.o_busy); end
    tick();
    n_cmp++; if (bus.o_done !== 1'b0) begin n_bad++; $display("FAIL basic_done_pulse: got %b want 0", bus.o_done); end
  endtask

  task automatic test_exact_and_far();
    desc_t c [8];
    int    lat;
    c[0] = '1; c[1] = '0;
    start_query('1);
    send_cands(c, 2);
    wait_done(lat);
    n_cmp++; if (lat != 4) begin n_bad++; $display("FAIL far_latency: got %0d want 4", lat); end
    n_cmp++; if (bus.o_best_idx !== 10'd0) begin n_bad++; $display("FAIL far_idx: got %0d want 0", bus.o_best_idx); end
    n_cmp++; if (bus.o_best_dist !== 9'd0) begin n_bad++; $display("FAIL far_best: got %0d want 0", bus.o_best_dist); end
    n_cmp++; if (bus.o_second_dist !== 9'd256) begin n_bad++; $display("FAIL far_second: got %0d want 256", bus.o_second_dist); end
    n_cmp++; if (bus.o_match_ok !== 1'b1) begin n_bad++; $display("FAIL far_ok: got %b want 1", bus.o_match_ok); end
  endtask

  task automatic test_threshold();
    desc_t c [8];
    int    lat;
    c[0] = ones_n(65);
    start_query('0);
    send_cands(c, 1);
    wait_done(lat);
    n_cmp++; if (bus.o_best_dist !== 9'd65) begin n_bad++; $display("FAIL thr65_best: got %0d want 65", bus.o_best_dist); end
    n_cmp++; if (bus.o_second_dist !== 9'd511) begin n_bad++; $display("FAIL thr65_second: got %0d want 511", bus.o_second_dist); end
    n_cmp++; if (bus.o_match_ok !== 1'b0) begin n_bad++; $display("FAIL thr65_ok: got %b want 0", bus.o_match_ok); end
    c[0] = ones_n(64);
    start_query('0);
    send_cands(c, 1);
    wait_done(lat);
    n_cmp++; if (bus.o_best_dist !== 9'd64) begin n_bad++; $display("FAIL thr64_best: got %0d want 64", bus.o_best_dist); end
    n_cmp++; if (bus.o_match_ok !== 1'b1) begin n_bad++; $display("FAIL thr64_ok: got %b want 1", bus.o_match_ok); end
  endtask

  task automatic test_ratio();
    desc_t c [8];
    int    lat;
    c[0] = ones_n(30); c[1] = ones_n(40);
    start_query('0);
    send_cands(c, 2);
    wait_done(lat);
    n_cmp++; if (bus.o_best_dist !== 9'd30) begin n_bad++; $display("FAIL r30_best: got %0d want 30", bus.o_best_dist); end
    n_cmp++; if (bus.o_match_ok !== 1'b0) begin n_bad++; $display("FAIL r30_ok: got %b want 0", bus.o_match_ok); end
    c[0] = ones_n(29);
    start_query('0);
    send_cands(c, 2);
    wait_done(lat);
    n_cmp++; if (bus.o_second_dist !== 9'd40) begin n_bad++; $display("FAIL r29_second: got %0d want 40", bus.o_second_dist); end
    n_cmp++; if (bus.o_match_ok !== 1'b1) begin n_bad++; $display("FAIL r29_ok: got %b want 1", bus.o_match_ok); end
  endtask

  task automatic test_reset_midflight();
    desc_t c [8];
    int    lat;
    int    dones;
    c[0] = ones_n(3); c[1] = ones_n(7);
    start_query('0);
    send_cands(c, 2);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (bus.o_busy !== 1'b0) begin n_bad++; $display("FAIL mid_busy: got %b want 0", bus.o_busy); end
    n_cmp++; if (bus.o_best_dist !== 9'd511) begin n_bad++; $display("FAIL mid_best: got %0d want 511", bus.o_best_dist); end
    n_cmp++; if (bus.o_second_dist !== 9'd511) begin n_bad++; $display("FAIL mid_second: got %0d want 511", bus.o_second_dist); end
    n_cmp++; if (bus.o_match_ok !== 1'b0) begin n_bad++; $display("FAIL mid_ok: got %b want 0", bus.o_match_ok); end
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.o_done) dones++;
      tick();
    end
    n_cmp++; if (dones != 0) begin n_bad++; $display("FAIL mid_no_done: got %0d want 0", dones); end
    c[0] = ones_n(5); c[1] = ones_n(9);
    start_query('0);
    send_cands(c, 2);
    wait_done(lat);
    n_cmp++; if (lat != 4) begin n_bad++; $display("FAIL mid_new_latency: got %0d want 4", lat); end
    n_cmp++; if (bus.o_best_dist !== 9'd5) begin n_bad++; $display("FAIL mid_new_best: got %0d want 5", bus.o_best_dist); end
    n_cmp++; if (bus.o_second_dist !== 9'd9) begin n_bad++; $display("FAIL mid_new_second: got %0d want 9", bus.o_second_dist); end
    n_cmp++; if (bus.o_match_ok !== 1'b1) begin n_bad++; $display("FAIL mid_new_ok: got %b want 1", bus.o_match_ok); end
  endtask

  task automatic test_back_to_back();
    desc_t c [8];
    int    lat;
    c[0] = ones_n(10); c[1] = ones_n(20);
    start_query('0);
    send_cands(c, 2);
    bus.i_cand_valid = 1'b1;
    bus.i_cand       = '0;
    bus.i_cand_last  = 1'b1;
    wait_done(lat);
    n_cmp++; if (lat != 4) begin n_bad++; $display("FAIL b2b_a_latency: got %0d want 4", lat); end
    n_cmp++; if (bus.o_best_dist !== 9'd10) begin n_bad++; $display("FAIL b2b_a_best: got %0d want 10", bus.o_best_dist); end
    n_cmp++; if (bus.o_second_dist !== 9'd20) begin n_bad++; $display("FAIL b2b_a_second: got %0d want 20", bus.o_second_dist); end
    n_cmp++; if (bus.o_match_ok !== 1'b1) begin n_bad++; $display("FAIL b2b_a_ok: got %b want 1", bus.o_match_ok); end
    bus.i_start     = 1'b1;
    bus.i_query     = '1;
    bus.i_cand      = '1;
    bus.i_cand_last = 1'b0;
    tick();
    bus.i_start = 1'b0;
    n_cmp++; if (bus.o_busy !== 1'b1) begin n_bad++; $display("FAIL b2b_restart_busy: got %b want 1", bus.o_busy); end
    n_cmp++; if (bus.o_done !== 1'b0) begin n_bad++; $display("FAIL b2b_restart_done: got %b want 0", bus.o_done); end
    c[0] = ~ones_n(50); c[1] = ~ones_n(30);
    send_cands(c, 2);
    n_cmp++; if (bus.o_best_dist !== 9'd10) begin n_bad++; $display("FAIL b2b_hold_best: got %0d want 10", bus.o_best_dist); end
    wait_done(lat);
    n_cmp++; if (lat != 4) begin n_bad++; $display("FAIL b2b_b_latency: got %0d want 4", lat); end
    n_cmp++; if (bus.o_best_idx !== 10'd1) begin n_bad++; $display("FAIL b2b_b_idx: got %0d want 1", bus.o_best_idx); end
    n_cmp++; if (bus.o_best_dist !== 9'd30) begin n_bad++; $display("FAIL b2b_b_best: got %0d want 30", bus.o_best_dist); end
    n_cmp++; if (bus.o_second_dist !== 9'd50) begin n_bad++; $display("FAIL b2b_b_second: got %0d want 50", bus.o_second_dist); end
    n_cmp++; if (bus.o_match_ok !== 1'b1) begin n_bad++; $display("FAIL b2b_b_ok: got %b want 1", bus.o_match_ok); end
  endtask

  initial begin
    bus.i_start      = 1'b0;
    bus.i_query      = '0;
    bus.i_cand_valid = 1'b0;
    bus.i_cand       = '0;
    bus.i_cand_last  = 1'b0;
    test_reset();
    test_basic();
    test_exact_and_far();
    test_threshold();
    test_ratio();
    test_reset_midflight();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
